// File: rtl/outcome_pkg.sv
// Shared codes for the N x N outcome scanner:
// cell, outcome, direction and FSM state encodings.
package outcome_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    P1      = 2'd1,
    P2      = 2'd2,
    INVALID = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    IN_PROGRESS = 2'd0,
    P1_WIN      = 2'd1,
    P1_LOSE     = 2'd2,
    TIE         = 2'd3
  } outcome_t;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/outcome_scanner_if.sv
// Start/done bundle between game control (master)
// and the outcome scanner (slave).
interface outcome_scanner_if
  import outcome_pkg::*;
#(
  parameter int N = 3
);
  localparam int RW = $clog2(N);

  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  outcome_t          outcome;
  logic [RW-1:0]     win_row;
  logic [RW-1:0]     win_col;
  dir_t              win_dir;

  modport master (
    output start, board,
    input  busy, done, outcome,
    input  win_row, win_col, win_dir
  );

  modport slave (
    input  start, board,
    output busy, done, outcome,
    output win_row, win_col, win_dir
  );
endinterface

// File: rtl/outcome_scanner_line_check.sv
// Checks one K-long line from anchor (r,c) in one
// direction: on-board validity and same-player run.
module line_check
  import outcome_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [2*N*N-1:0]    snap,
  input  logic [$clog2(N)-1:0] r,
  input  logic [$clog2(N)-1:0] c,
  input  dir_t                dir,
  output logic                valid,
  output logic                win,
  output cell_t               player
);
  int   dr;
  int   dc;
  int   er;
  int   ec;
  int   idx;
  logic same;

  // walk K cells from the anchor and compare to it
  always_comb begin
    dr     = 0;
    dc     = 1;
    er     = 0;
    ec     = 0;
    idx    = 0;
    same   = 1'b0;
    player = EMPTY;
    unique case (dir)
      DIR_H: begin dr = 0; dc = 1;  end
      DIR_V: begin dr = 1; dc = 0;  end
      DIR_D: begin dr = 1; dc = 1;  end
      DIR_A: begin dr = 1; dc = -1; end
    endcase
    er    = int'(r) + (K - 1) * dr;
    ec    = int'(c) + (K - 1) * dc;
    valid = (int'(r) < N) && (int'(c) < N) &&
            (er < N) && (ec >= 0) && (ec < N);
    if (valid) begin
      idx    = int'(r) * N + int'(c);
      player = cell_t'(snap[2*idx +: 2]);
      same   = 1'b1;
      for (int k = 1; k < K; k++) begin
        idx = (int'(r) + k * dr) * N + int'(c) + k * dc;
        if (snap[2*idx +: 2] != player)
          same = 1'b0;
      end
    end
    win = same && (player == P1 || player == P2);
  end
endmodule

// File: rtl/outcome_scanner.sv
// N x N K-in-a-row evaluator: snapshots the board on
// start and scans one anchor per clock until a win or the end.
module outcome_scanner
  import outcome_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic          clk,
  input logic          rst,
  outcome_scanner_if.slave bus
);
  localparam int RW = $clog2(N);
  localparam int IW = $clog2(N*N);
  localparam int EW = $clog2(N*N+1);
  localparam int BW = 2*N*N;

  state_t          state_q, state_d;
  logic [BW-1:0]   snap_q, snap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [EW-1:0]   empty_q, empty_d;
  outcome_t        out_q, out_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   col_q, col_d;
  dir_t            dir_q, dir_d;

  logic [RW-1:0]   r_w;
  logic [RW-1:0]   c_w;
  logic [3:0]      lc_valid;
  logic [3:0]      lc_win;
  cell_t           lc_player [4];
  logic            hit;
  dir_t            hit_dir;
  cell_t           hit_player;
  logic            anchor_empty;
  logic            last;

  assign r_w = RW'(idx_q / IW'(N));
  assign c_w = RW'(idx_q % IW'(N));

  for (genvar d = 0; d < 4; d++) begin : g_lc
    line_check #(.N(N), .K(K)) u_lc (
      .snap   (snap_q),
      .r      (r_w),
      .c      (c_w),
      .dir    (dir_t'(d)),
      .valid  (lc_valid[d]),
      .win    (lc_win[d]),
      .player (lc_player[d])
    );
  end

  // first winning direction in H, V, D, A order
  always_comb begin
    hit        = 1'b0;
    hit_dir    = DIR_H;
    hit_player = EMPTY;
    for (int d = 0; d < 4; d++) begin
      if (!hit && lc_valid[d] && lc_win[d]) begin
        hit        = 1'b1;
        hit_dir    = dir_t'(2'(d));
        hit_player = lc_player[d];
      end
    end
  end

  assign anchor_empty = (snap_q[2*int'(idx_q) +: 2] == EMPTY);
  assign last         = (idx_q == IW'(N*N-1));

  // next state, scan counters and result latching
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    empty_d = empty_q;
    out_d   = out_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d  = bus.board;
          idx_d   = '0;
          empty_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          out_d   = (hit_player == P1) ? P1_WIN : P1_LOSE;
          row_d   = r_w;
          col_d   = c_w;
          dir_d   = hit_dir;
          state_d = S_DONE;
        end else begin
          empty_d = empty_q + EW'(anchor_empty);
          if (last) begin
            out_d   = (empty_d == '0) ? TIE : IN_PROGRESS;
            row_d   = '0;
            col_d   = '0;
            dir_d   = DIR_H;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and result registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      empty_q <= '0;
      out_q   <= IN_PROGRESS;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= DIR_H;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      empty_q <= empty_d;
      out_q   <= out_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.outcome = out_q;
  assign bus.win_row = row_q;
  assign bus.win_col = col_q;
  assign bus.win_dir = dir_q;
endmodule

// File: tb/tb_outcome_scanner.sv
// Bench for outcome_scanner: 3x3/K3 and 5x5/K4 instances,
// vector table plus scoreboard of expected results.
module tb_outcome_scanner;
  import outcome_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  outcome_scanner_if #(.N(3)) bus3 ();
  outcome_scanner_if #(.N(5)) bus5 ();

  outcome_scanner #(.N(3), .K(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  outcome_scanner #(.N(5), .K(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  typedef struct {
    int    lat;
    int    oc;
    int    row;
    int    col;
    int    dir;
    string name;
  } exp_t;

  typedef struct {
    int    sel;
    string bs;
    int    poke;
    exp_t  e;
  } vec_t;

  exp_t sbq [$];
  vec_t tbl [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [49:0] bstr(string s);
    logic [49:0] b;
    byte ch;
    b = '0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i] - 8'd48;
      b[2*i +: 2] = ch[1:0];
    end
    return b;
  endfunction

  function automatic int o_done(int sel);
    return (sel == 3) ? int'(bus3.done) : int'(bus5.done);
  endfunction
  function automatic int o_busy(int sel);
    return (sel == 3) ? int'(bus3.busy) : int'(bus5.busy);
  endfunction
  function automatic int o_oc(int sel);
    return (sel == 3) ? int'(bus3.outcome) : int'(bus5.outcome);
  endfunction
  function automatic int o_row(int sel);
    return (sel == 3) ? int'(bus3.win_row) : int'(bus5.win_row);
  endfunction
  function automatic int o_col(int sel);
    return (sel == 3) ? int'(bus3.win_col) : int'(bus5.win_col);
  endfunction
  function automatic int o_dir(int sel);
    return (sel == 3) ? int'(bus3.win_dir) : int'(bus5.win_dir);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [49:0] b,
                       input logic s);
    if (sel == 3) begin
      bus3.board = b[17:0];
      bus3.start = s;
    end else begin
      bus5.board = b;
      bus5.start = s;
    end
  endtask

  task automatic run(input vec_t v);
    int   cnt;
    int   seen;
    bit   got;
    exp_t e;
    sbq.push_back(v.e);
    drive(v.sel, bstr(v.bs), 1'b1);
    @(posedge clk); #1;
    cnt = 1;
    drive(v.sel, bstr(v.bs), 1'b0);
    check({v.e.name, ".busy"}, o_busy(v.sel), 1);
    got = 1'b0;
    while (!got && cnt < 60) begin
      if (o_done(v.sel) == 1) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        cnt++;
        if (v.poke != 0 && cnt == v.poke)
          drive(v.sel, bstr("1111111111111111111111111"), 1'b1);
        else if (v.poke != 0 && cnt == v.poke + 1)
          drive(v.sel, bstr("1111111111111111111111111"), 1'b0);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: no done after %0d cycles",
               v.e.name, cnt);
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      check({e.name, ".lat"}, cnt, e.lat);
      check({e.name, ".outcome"}, o_oc(v.sel), e.oc);
      check({e.name, ".row"}, o_row(v.sel), e.row);
      check({e.name, ".col"}, o_col(v.sel), e.col);
      check({e.name, ".dir"}, o_dir(v.sel), e.dir);
      @(posedge clk); #1;
      check({e.name, ".done_pulse"}, o_done(v.sel), 0);
      check({e.name, ".busy_fall"}, o_busy(v.sel), 0);
      check({e.name, ".hold"}, o_oc(v.sel), e.oc);
      if (v.poke != 0) begin
        seen = 0;
        for (int i = 0; i < 12; i++) begin
          @(posedge clk); #1;
          if (o_done(v.sel) == 1) seen++;
        end
        check({e.name, ".no_requeue"}, seen, 0);
      end
    end
  endtask

  initial begin
    int   seen;
    vec_t fresh;

    bus3.start = 1'b0;
    bus3.board = '0;
    bus5.start = 1'b0;
    bus5.board = '0;

    tbl.push_back('{5, "0000200020002000200000000", 0,
                    '{6, 2, 0, 4, 3, "n5_anti_p2"}});
    tbl.push_back('{5, "0000000000000000000001111", 0,
                    '{23, 1, 4, 1, 0, "n5_row4_p1"}});
    tbl.push_back('{5, "0000000000000000000000000", 0,
                    '{26, 0, 0, 0, 0, "n5_empty"}});
    tbl.push_back('{3, "111000000", 0,
                    '{2, 1, 0, 0, 0, "row0_p1"}});
    tbl.push_back('{3, "111100100", 0,
                    '{2, 1, 0, 0, 0, "h_over_v"}});
    tbl.push_back('{3, "121122211", 0,
                    '{10, 3, 0, 0, 0, "draw"}});
    tbl.push_back('{3, "000000000", 3,
                    '{10, 0, 0, 0, 0, "empty_ign"}});
    tbl.push_back('{3, "321122211", 0,
                    '{10, 3, 0, 0, 0, "inv_tie"}});
    tbl.push_back('{3, "333000000", 0,
                    '{10, 0, 0, 0, 0, "inv_line"}});
    tbl.push_back('{3, "102102102", 0,
                    '{2, 1, 0, 0, 1, "col0_p1"}});
    tbl.push_back('{3, "233020002", 0,
                    '{2, 2, 0, 0, 2, "diag_p2"}});
    tbl.push_back('{3, "000000222", 0,
                    '{8, 2, 2, 0, 0, "row2_p2"}});
    tbl.push_back('{3, "001010100", 0,
                    '{4, 1, 0, 2, 3, "anti_p1"}});

    #1;
    check("rst.busy", o_busy(3), 0);
    check("rst.done", o_done(3), 0);
    check("rst.outcome", o_oc(3), 0);
    check("rst.busy5", o_busy(5), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run(tbl[i]);

    drive(3, bstr("000000000"), 1'b1);
    @(posedge clk); #1;
    drive(3, bstr("000000000"), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(3, bstr("000000000"), 1'b1);
    @(posedge clk); #1;
    drive(3, bstr("000000000"), 1'b0);
    @(posedge clk); #1;
    check("abort.busy_pre", o_busy(3), 1);
    check("abort.oc_pre", o_oc(3), 1);
    rst = 1'b0;
    #1;
    check("abort.busy", o_busy(3), 0);
    check("abort.done", o_done(3), 0);
    check("abort.outcome", o_oc(3), 0);
    check("abort.row", o_row(3), 0);
    check("abort.col", o_col(3), 0);
    check("abort.dir", o_dir(3), 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (o_done(3) == 1) seen++;
    end
    check("abort.no_done", seen, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    fresh = '{3, "000000111", 0,
              '{8, 1, 2, 0, 0, "post_rst"}};
    run(fresh);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
